legv8_regfile: RTL and testbench

- LEGv8 integer register file for the datapath: 32 x 64-bit entries, one write port (write-back stage), two read ports (register-fetch stage).
- Read ports are registered: address and enable in on one edge, data plus a valid strobe out after the next edge.
- Index 31 is XZR: it always reads 0 and ignores writes.
- Write-to-read bypass is included, so a read issued in the same cycle as a write to that register returns the new value.

---
 rtl/legv8_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 50 +++++
 rtl/legv8_regfile.sv | 85 ++++++++
 tb/tb_legv8_regfile.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared widths and types for the LEGv8 integer register file.
// XZR_IDX names the architectural zero register.
package legv8_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int XZR_IDX    = 31;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]     xword_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: XZR check, write-to-read bypass, output register.
// Output data holds its value while read_en is low.
module regfile_read_port
    import legv8_pkg::*;
#(
    parameter int DATA_W   = legv8_pkg::DATA_W,
    parameter int ADDR_W   = legv8_pkg::REG_ADDR_W,
    parameter int ZERO_REG = legv8_pkg::XZR_IDX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] entries [2**ADDR_W],
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] read_data_reg;
    logic [DATA_W-1:0] read_data_next;

    // The zero check comes first so a write to XZR can never bypass into a read.
    always_comb begin
        read_data_next = read_data_reg;
        if (read_en) begin
            if (read_addr == ZERO_IDX) begin
                read_data_next = '0;
            end else if (write_en && (write_addr == read_addr)) begin
                read_data_next = write_data;
            end else begin
                read_data_next = entries[read_addr];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data_reg <= '0;
        end else begin
            read_data_reg <= read_data_next;
        end
    end

    assign read_data = read_data_reg;

endmodule

// File: rtl/legv8_regfile.sv
// LEGv8 register file: 32 x 64-bit, one write port, two registered read ports.
// Entries are flops (not block RAM) because reset must clear every one of them.
module legv8_regfile
    import legv8_pkg::*;
#(
    parameter int DATA_W   = legv8_pkg::DATA_W,
    parameter int ADDR_W   = legv8_pkg::REG_ADDR_W,
    parameter int ZERO_REG = legv8_pkg::XZR_IDX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_valid,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] entries [DEPTH];
    logic              read_valid_reg;
    logic [ADDR_W-1:0] port_addr [2];
    logic [DATA_W-1:0] port_data [2];

    // XZR gets no storage at all; every other index is a plain enabled register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == ZERO_REG) begin : g_zero
                assign entries[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] entry_reg;
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        entry_reg <= '0;
                    end else if (write_en && (write_addr == ADDR_W'(gi))) begin
                        entry_reg <= write_data;
                    end
                end
                assign entries[gi] = entry_reg;
            end
        end
    endgenerate

    assign port_addr[0] = read_addr1;
    assign port_addr[1] = read_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .clock      (clock),
                .reset      (reset),
                .entries    (entries),
                .write_en   (write_en),
                .write_addr (write_addr),
                .write_data (write_data),
                .read_en    (read_en),
                .read_addr  (port_addr[gi]),
                .read_data  (port_data[gi])
            );
        end
    endgenerate

    assign read_data1 = port_data[0];
    assign read_data2 = port_data[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_valid_reg <= 1'b0;
        end else begin
            read_valid_reg <= read_en;
        end
    end

    assign read_valid = read_valid_reg;

endmodule

// File: tb/tb_legv8_regfile.sv
// Directed bench for legv8_regfile: vector table plus reset corner sequences.
module tb_legv8_regfile;
    import legv8_pkg::*;

    logic     clock = 1'b0;
    logic     reset;
    logic     read_en;
    reg_idx_t read_addr1, read_addr2;
    xword_t   read_data1, read_data2;
    logic     read_valid;
    logic     write_en;
    reg_idx_t write_addr;
    xword_t   write_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic     we;
        reg_idx_t wa;
        xword_t   wd;
        logic     re;
        reg_idx_t a1;
        reg_idx_t a2;
        xword_t   e1;
        xword_t   e2;
        logic     ev;
    } vec_t;

    vec_t vecs [14];

    legv8_regfile dut (
        .clock      (clock),
        .reset      (reset),
        .read_en    (read_en),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .read_valid (read_valid),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input xword_t act, input xword_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input xword_t e1, input xword_t e2, input logic ev);
        check({tag, ".data1"}, read_data1, e1);
        check({tag, ".data2"}, read_data2, e2);
        check({tag, ".valid"}, xword_t'(read_valid), xword_t'(ev));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Hand-computed: each row is driven before a posedge, outputs checked just after it.
        vecs[0]  = '{1'b1, 5'd5,  64'h0123_4567_89AB_CDEF, 1'b0, 5'd0,  5'd0,  64'h0, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,                   1'b1, 5'd5,  5'd0,  64'h0123_4567_89AB_CDEF, 64'h0, 1'b1};
        vecs[2]  = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd9,  5'd9,  64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[3]  = '{1'b1, 5'd7,  64'h11,                  1'b0, 5'd0,  5'd0,  64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[4]  = '{1'b1, 5'd7,  64'hFFFF_0000_FFFF_0000, 1'b1, 5'd7,  5'd7,  64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 1'b1};
        vecs[5]  = '{1'b1, 5'd31, 64'hDEAD,                1'b1, 5'd31, 5'd7,  64'h0, 64'hFFFF_0000_FFFF_0000, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  64'h0,                   1'b1, 5'd31, 5'd31, 64'h0, 64'h0, 1'b1};
        vecs[7]  = '{1'b1, 5'd1,  64'hA,                   1'b0, 5'd0,  5'd0,  64'h0, 64'h0, 1'b0};
        vecs[8]  = '{1'b1, 5'd2,  64'hB,                   1'b0, 5'd0,  5'd0,  64'h0, 64'h0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  64'h0,                   1'b1, 5'd1,  5'd2,  64'hA, 64'hB, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  64'h0,                   1'b1, 5'd2,  5'd1,  64'hB, 64'hA, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  64'h0,                   1'b0, 5'd7,  5'd7,  64'hB, 64'hA, 1'b0};
        vecs[12] = '{1'b1, 5'd4,  64'h44,                  1'b1, 5'd4,  5'd5,  64'h44, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[13] = '{1'b1, 5'd5,  64'h55,                  1'b1, 5'd4,  5'd5,  64'h44, 64'h55, 1'b1};

        reset      = 1'b0;
        read_en    = 1'b0;
        read_addr1 = '0;
        read_addr2 = '0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        #1;
        $display("txn reset-at-start d1=%h d2=%h v=%b", read_data1, read_data2, read_valid);
        check_outs("reset_start", 64'h0, 64'h0, 1'b0);

        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            write_en   = vecs[i].we;
            write_addr = vecs[i].wa;
            write_data = vecs[i].wd;
            read_en    = vecs[i].re;
            read_addr1 = vecs[i].a1;
            read_addr2 = vecs[i].a2;
            @(posedge clock);
            #1;
            $display("txn vec%0d we=%b wa=%0d re=%b a1=%0d a2=%0d d1=%h d2=%h v=%b",
                     i, vecs[i].we, vecs[i].wa, vecs[i].re, vecs[i].a1, vecs[i].a2,
                     read_data1, read_data2, read_valid);
            check_outs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ev);
        end

        // Asynchronous reset between edges must clear outputs immediately.
        write_en = 1'b0;
        read_en  = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        $display("txn mid-cycle-reset d1=%h d2=%h v=%b", read_data1, read_data2, read_valid);
        check_outs("reset_mid", 64'h0, 64'h0, 1'b0);

        // A write and read presented while reset is held are both lost.
        @(negedge clock);
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 64'h55;
        read_en    = 1'b1;
        read_addr1 = 5'd3;
        read_addr2 = 5'd5;
        @(posedge clock);
        #1;
        $display("txn write-during-reset d1=%h d2=%h v=%b", read_data1, read_data2, read_valid);
        check_outs("reset_hold", 64'h0, 64'h0, 1'b0);

        @(negedge clock);
        reset    = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        @(posedge clock);
        #1;
        $display("txn post-release idle v=%b", read_valid);
        check("post_release.valid", xword_t'(read_valid), 64'h0);

        // Every entry, including previously written ones, must read back zero.
        for (int i = 0; i < 31; i++) begin
            @(negedge clock);
            read_en    = 1'b1;
            read_addr1 = reg_idx_t'(i);
            read_addr2 = reg_idx_t'(30 - i);
            @(posedge clock);
            #1;
            $display("txn sweep a1=%0d a2=%0d d1=%h d2=%h v=%b",
                     i, 30 - i, read_data1, read_data2, read_valid);
            check_outs($sformatf("sweep%0d", i), 64'h0, 64'h0, 1'b1);
        end

        @(negedge clock);
        read_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
